// File: rtl/keypad_encoder.sv
// keypad_encoder
// Scans a 4x3 matrix keypad, debounces presses and releases, and encodes the
// confirmed key into the 4-bit lock code (0-9 -> 0..9, * -> 10, # -> 11).
//
// Parameters:
//   SCAN_DIV      clocks per row slot (>= 2); one sample per slot
//   DEBOUNCE_CNT  consecutive matching samples to confirm a press or release (>= 1)
//
// Ports:
//   clk         single clock, rising edge
//   reset_1     synchronous, active-high reset
//   col_in      keypad columns, active-low, asynchronous to clk
//   row_out     row drive, active-low one-hot
//   Code_1      last confirmed key code (registered)
//   Valid_1     code strobe: one-clock pulse, or a level while held
//   key_held    high while a confirmed key is down
//   scan_state  current FSM state (0 = SCAN, 1 = DEBOUNCE, 2 = PRESSED)
//
// Build option:
//   KEYPAD_HOLD_EN  when defined, Valid_1 stays high from confirm until the key
//                   is released (falls together with key_held); otherwise
//                   Valid_1 is a single-clock pulse per confirmed press.
//
// Handshake: Code_1 is valid whenever Valid_1 is high; the consumer has no
// back-pressure (there is no ready), so each strobe must be taken when seen.
module keypad_encoder #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset_1,
  input  logic [2:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] Code_1,
  output logic       Valid_1,
  output logic       key_held,
  output logic [1:0] scan_state
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  // Counters must be able to hold DEBOUNCE_CNT itself.
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [1:0]       row, row_n;
  logic [1:0]       col, col_n;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] deb_cnt, deb_n;
  logic [CNT_W-1:0] rel_cnt, rel_n;
  logic [2:0]       sync_a, sync_b;
  logic [3:0]       code, code_n;
  logic             valid, valid_n;

  logic             sample;
  logic             single;
  logic [1:0]       col_idx;
  logic             latched_low;

  // Key label to lock code; row 3 holds * 0 # rather than a digit run.
  function automatic logic [3:0] encode(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] res;
    if (r == 2'd3) begin
      case (c)
        2'd0:    res = 4'd10;
        2'd1:    res = 4'd0;
        default: res = 4'd11;
      endcase
    end else begin
      res = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
    end
    return res;
  endfunction

  assign sample = (div_cnt == DIV_LAST);

  // Exactly one column pulled low on the synchronized columns.
  always_comb begin
    single  = 1'b1;
    col_idx = 2'd0;
    case (sync_b)
      3'b110:  col_idx = 2'd0;
      3'b101:  col_idx = 2'd1;
      3'b011:  col_idx = 2'd2;
      default: single  = 1'b0;
    endcase
  end

  always_comb begin
    case (col)
      2'd0:    latched_low = ~sync_b[0];
      2'd1:    latched_low = ~sync_b[1];
      default: latched_low = ~sync_b[2];
    endcase
  end

  // Next-state logic; every decision happens only on a sample cycle.
  always_comb begin
    state_n = state;
    row_n   = row;
    col_n   = col;
    deb_n   = deb_cnt;
    rel_n   = rel_cnt;
    code_n  = code;
`ifdef KEYPAD_HOLD_EN
    valid_n = valid;
`else
    valid_n = 1'b0;
`endif
    if (sample) begin
      case (state)
        ST_SCAN: begin
          if (single) begin
            col_n = col_idx;
            if (DEBOUNCE_CNT == 1) begin
              code_n  = encode(row, col_idx);
              valid_n = 1'b1;
              deb_n   = '0;
              state_n = ST_PRESSED;
            end else begin
              deb_n   = CNT_W'(1);
              state_n = ST_DEBOUNCE;
            end
          end else begin
            row_n = row + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (single && (col_idx == col)) begin
            if (deb_cnt >= CNT_LAST) begin
              code_n  = encode(row, col);
              valid_n = 1'b1;
              deb_n   = '0;
              state_n = ST_PRESSED;
            end else begin
              deb_n = deb_cnt + CNT_W'(1);
            end
          end else begin
            deb_n   = '0;
            row_n   = row + 2'd1;
            state_n = ST_SCAN;
          end
        end
        ST_PRESSED: begin
          // Only the latched column matters; other keys are ignored.
          if (!latched_low) begin
            if (rel_cnt >= CNT_LAST) begin
              rel_n   = '0;
              row_n   = row + 2'd1;
              state_n = ST_SCAN;
`ifdef KEYPAD_HOLD_EN
              valid_n = 1'b0;
`endif
            end else begin
              rel_n = rel_cnt + CNT_W'(1);
            end
          end else begin
            rel_n = '0;
          end
        end
        default: begin
          state_n = ST_SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_1) begin
      state   <= ST_SCAN;
      row     <= 2'd0;
      col     <= 2'd0;
      div_cnt <= '0;
      deb_cnt <= '0;
      rel_cnt <= '0;
      sync_a  <= 3'b111;
      sync_b  <= 3'b111;
      code    <= 4'd0;
      valid   <= 1'b0;
    end else begin
      state   <= state_n;
      row     <= row_n;
      col     <= col_n;
      div_cnt <= sample ? '0 : div_cnt + DIV_W'(1);
      deb_cnt <= deb_n;
      rel_cnt <= rel_n;
      sync_a  <= col_in;
      sync_b  <= sync_a;
      code    <= code_n;
      valid   <= valid_n;
    end
  end

  always_comb begin
    case (row)
      2'd0:    row_out = 4'b1110;
      2'd1:    row_out = 4'b1101;
      2'd2:    row_out = 4'b1011;
      default: row_out = 4'b0111;
    endcase
  end

  assign Code_1     = code;
  assign Valid_1    = valid;
  assign key_held   = (state == ST_PRESSED);
  assign scan_state = state;

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder with SCAN_DIV = 4, DEBOUNCE_CNT = 3.
// A physical keypad model turns the set of pressed keys plus row_out into
// col_in. A monitor pairs each Valid_1 rising edge with the code expected
// from the scoreboard queue.
module tb_keypad_encoder;

  logic       clk;
  logic       reset_1;
  logic [2:0] col_in;
  logic [3:0] row_out;
  logic [3:0] Code_1;
  logic       Valid_1;
  logic       key_held;
  logic [1:0] scan_state;

  logic [3:0][2:0] pressed;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_events = 0;
  logic [3:0] last_code = 4'd0;
  logic prev_v = 1'b0;
  logic [3:0] exp_q[$];

  typedef struct {
    int         r;
    int         c;
    logic [3:0] code;
  } vec_t;
  vec_t vecs[12];

  keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk        (clk),
    .reset_1    (reset_1),
    .col_in     (col_in),
    .row_out    (row_out),
    .Code_1     (Code_1),
    .Valid_1    (Valid_1),
    .key_held   (key_held),
    .scan_state (scan_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- keypad model ----------------
  always_comb begin
    col_in = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r][c] && !row_out[r]) col_in[c] = 1'b0;
  end

  // ---------------- reference model ----------------
  function automatic logic [3:0] key_code(input int r, input int c);
    string lbl;
    byte   ch;
    lbl = "123456789*0#";
    ch  = lbl[r*3 + c];
    if (ch == "*") return 4'd10;
    if (ch == "#") return 4'd11;
    return 4'(ch - "0");
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    #1;
    if (!reset_1) begin
      if (Valid_1 && !prev_v) begin
        valid_events++;
        last_code = Code_1;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got code %0h with no press pending", Code_1);
        end else begin
          check("valid_code", Code_1, exp_q.pop_front());
        end
      end
`ifdef KEYPAD_HOLD_EN
      if (Valid_1 || key_held) check("hold_level_vs_key_held", Valid_1, key_held);
`else
      if (Valid_1) check("valid_pulse_width", prev_v, 1'b0);
`endif
    end
    prev_v = Valid_1;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int start;
    int n;
    start = valid_events;
    n = 0;
    while (valid_events == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(valid_events != start), 32'd1);
  endtask

  // Returns clocks from call until key_held is seen low (budget+1 on timeout).
  task automatic wait_release(input string name, input int budget, output int n);
    n = 0;
    while (key_held && n <= budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(key_held), 32'd0);
  endtask

  task automatic wait_row(input logic [3:0] val, input bit eq, input int budget);
    int n;
    n = 0;
    while (((row_out == val) != eq) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_row_timeout", 32'((row_out == val) == eq), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int start;
    int n;
    int run;
    int changes;
    int r;
    int c;
    logic [3:0] prev_row;
    logic [3:0] exp_row;
    bit saw_valid;

    vecs[0]  = '{0, 0, 4'd1};  vecs[1]  = '{0, 1, 4'd2};  vecs[2]  = '{0, 2, 4'd3};
    vecs[3]  = '{1, 0, 4'd4};  vecs[4]  = '{1, 1, 4'd5};  vecs[5]  = '{1, 2, 4'd6};
    vecs[6]  = '{2, 0, 4'd7};  vecs[7]  = '{2, 1, 4'd8};  vecs[8]  = '{2, 2, 4'd9};
    vecs[9]  = '{3, 0, 4'd10}; vecs[10] = '{3, 1, 4'd0};  vecs[11] = '{3, 2, 4'd11};

    pressed = '0;
    reset_1 = 1'b1;
    tick(3);
    check("reset_row_out",  row_out,  4'b1110);
    check("reset_code",     Code_1,   4'd0);
    check("reset_valid",    Valid_1,  1'b0);
    check("reset_key_held", key_held, 1'b0);
    reset_1 = 1'b0;

    // Idle scan: rows rotate every 4 clocks, no strobe.
    prev_row = row_out;
    run = 1;
    changes = 0;
    saw_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (Valid_1) saw_valid = 1'b1;
      if (row_out != prev_row) begin
        exp_row = {prev_row[2:0], prev_row[3]};
        check("idle_row_order", row_out, exp_row);
        if (changes > 0) check("idle_row_period", run, 4);
        changes++;
        prev_row = row_out;
        run = 1;
      end else begin
        run++;
      end
    end
    check("idle_no_valid", saw_valid, 1'b0);
    check("idle_enough_changes", 32'(changes >= 23), 32'd1);

    // Key 5 held 60 clocks: one strobe, then release timing.
    exp_q.push_back(key_code(1, 1));
    start = valid_events;
    pressed[1][1] = 1'b1;
    tick(60);
    check("key5_valid_count", valid_events - start, 1);
    check("key5_code", Code_1, 4'b0101);
    check("key5_held", key_held, 1'b1);
    pressed[1][1] = 1'b0;
    wait_release("key5_release_timeout", 30, n);
    check("key5_release_window", 32'(n >= 11 && n <= 14), 32'd1);
    tick(10);

    // # held: level strobe in the hold build, pulse otherwise.
    exp_q.push_back(key_code(3, 2));
    start = valid_events;
    pressed[3][2] = 1'b1;
    tick(60);
    check("hash_code", Code_1, 4'b1011);
    check("hash_valid_count", valid_events - start, 1);
`ifdef KEYPAD_HOLD_EN
    check("hash_valid_level", Valid_1, 1'b1);
`else
    check("hash_valid_level", Valid_1, 1'b0);
`endif
    pressed[3][2] = 1'b0;
    wait_release("hash_release_timeout", 30, n);
    check("hash_valid_after_release", Valid_1, 1'b0);
    tick(10);

    // Bounce on key 1: one low sample, one high sample, then stable.
    start = valid_events;
    wait_row(4'b1110, 1'b0, 20);
    wait_row(4'b1110, 1'b1, 20);
    pressed[0][0] = 1'b1;
    tick(4);
    pressed[0][0] = 1'b0;
    tick(4);
    check("bounce_no_valid", valid_events - start, 0);
    check("bounce_not_held", key_held, 1'b0);
    exp_q.push_back(key_code(0, 0));
    pressed[0][0] = 1'b1;
    wait_valid("bounce_valid_timeout", 60);
    check("bounce_code", Code_1, 4'b0001);
    pressed[0][0] = 1'b0;
    wait_release("bounce_release_timeout", 30, n);
    tick(10);

    // Keys 2 and 3 together: ignored until 3 lets go.
    start = valid_events;
    pressed[0][1] = 1'b1;
    pressed[0][2] = 1'b1;
    prev_row = row_out;
    changes = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (row_out != prev_row) changes++;
      prev_row = row_out;
    end
    check("two_keys_no_valid", valid_events - start, 0);
    check("two_keys_scanning", 32'(changes >= 10), 32'd1);
    exp_q.push_back(key_code(0, 1));
    pressed[0][2] = 1'b0;
    wait_valid("two_keys_valid_timeout", 60);
    check("two_keys_code", Code_1, 4'b0010);
    pressed[0][1] = 1'b0;
    wait_release("two_keys_release_timeout", 30, n);
    tick(10);

    // Reset during DEBOUNCE of *.
    start = valid_events;
    exp_q.push_back(key_code(3, 0));
    wait_row(4'b0111, 1'b0, 20);
    wait_row(4'b0111, 1'b1, 20);
    pressed[3][0] = 1'b1;
    tick(5);
    check("star_in_debounce_row_frozen", row_out, 4'b0111);
    check("star_no_valid_yet", valid_events - start, 0);
    reset_1 = 1'b1;
    tick(1);
    check("star_reset_row_out", row_out, 4'b1110);
    check("star_reset_valid", Valid_1, 1'b0);
    check("star_reset_held", key_held, 1'b0);
    reset_1 = 1'b0;
    wait_valid("star_valid_timeout", 60);
    check("star_code", Code_1, 4'b1010);
    pressed[3][0] = 1'b0;
    wait_release("star_release_timeout", 30, n);
    tick(10);

    // Table: every key once.
    for (int i = 0; i < 12; i++) begin
      start = valid_events;
      exp_q.push_back(vecs[i].code);
      pressed[vecs[i].r][vecs[i].c] = 1'b1;
      tick(50);
      check("tbl_valid_count", valid_events - start, 1);
      check("tbl_code", Code_1, vecs[i].code);
      check("tbl_held", key_held, 1'b1);
      pressed[vecs[i].r][vecs[i].c] = 1'b0;
      wait_release("tbl_release_timeout", 30, n);
      tick(8);
    end

    // Random presses with optional short glitch before the stable press.
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) begin
        pressed[r][c] = 1'b1;
        tick($urandom_range(1, 2));
        pressed[r][c] = 1'b0;
        tick(12);
      end
      start = valid_events;
      exp_q.push_back(key_code(r, c));
      pressed[r][c] = 1'b1;
      tick($urandom_range(40, 70));
      check("rnd_valid_count", valid_events - start, 1);
      check("rnd_code", Code_1, key_code(r, c));
      pressed[r][c] = 1'b0;
      wait_release("rnd_release_timeout", 30, n);
      tick($urandom_range(8, 30));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
